// File: rtl/spc_dump_reader_if.sv
// SPC dump bus bundle: stack RAM aux read port plus the debug-side entry stream.
// Latency: none; this file only groups the wires.
// Backpressure: the dout_ready wire carries the debug bus stall back to the reader.
interface spc_dump_reader_if #(
  parameter int AW = 5,
  parameter int DW = 19
);
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic [DW-1:0] dout;
  logic [AW-1:0] dout_idx;
  logic          dout_valid;
  logic          dout_ready;

  // Reader side: drives the RAM read port and the entry stream
  modport master (
    output rd_en, rd_addr, dout, dout_idx, dout_valid,
    input  rd_data, dout_ready
  );

  // Environment side: the stack RAM and the debug bus
  modport slave (
    input  rd_en, rd_addr, dout, dout_idx, dout_valid,
    output rd_data, dout_ready
  );
endinterface

// File: rtl/spc_dump_reader.sv
// Walks the SPC return stack from top of stack downward while halted, streaming entries to debug.
// Latency: first entry valid 3 cycles after start; 3 cycles per entry with ready held high.
// Backpressure: entry held stable while dout_ready is low; no further RAM reads until accepted.
module spc_dump_reader #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 19
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_halted,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_count,
  input  logic [ADDR_WIDTH-1:0] i_spcptr,
  spc_dump_reader_if.master     bus,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_aborted
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_PRESENT
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [ADDR_WIDTH-1:0] r_idx;
  logic [ADDR_WIDTH:0]   r_remaining;
  logic                  r_rd_en;
  logic [ADDR_WIDTH-1:0] r_rd_addr;
  logic [DATA_WIDTH-1:0] r_dout;
  logic [ADDR_WIDTH-1:0] r_dout_idx;
  logic                  r_dout_valid;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_aborted;

  logic [ADDR_WIDTH-1:0] w_idx_next;
  logic [ADDR_WIDTH-1:0] w_addr_next;
  logic [ADDR_WIDTH:0]   w_remaining_load;
  logic                  w_handshake;
  logic                  w_abort;

  // Next-entry address is computed from the latched base so spcptr moves mid-dump are ignored
  assign w_idx_next       = r_idx + ADDR_WIDTH'(1);
  assign w_addr_next      = r_base - w_idx_next;
  assign w_remaining_load = (i_count == '0) ? FULL_CNT : {1'b0, i_count};
  assign w_handshake      = r_dout_valid && bus.dout_ready;
  assign w_abort          = (r_state != S_IDLE) && !i_halted;

  // Dump sequencer; every output is registered and tracks the state it enters
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_base       <= '0;
      r_idx        <= '0;
      r_remaining  <= '0;
      r_rd_en      <= 1'b0;
      r_rd_addr    <= '0;
      r_dout       <= '0;
      r_dout_idx   <= '0;
      r_dout_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_aborted    <= 1'b0;
    end else begin
      r_rd_en <= 1'b0;
      r_done  <= 1'b0;
      if (w_abort) begin
        // Losing halt wins over everything, including a handshake this cycle
        r_state      <= S_IDLE;
        r_dout_valid <= 1'b0;
        r_busy       <= 1'b0;
        r_aborted    <= 1'b1;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (i_start && i_halted) begin
              r_state     <= S_READ;
              r_base      <= i_spcptr;
              r_idx       <= '0;
              r_remaining <= w_remaining_load;
              r_aborted   <= 1'b0;
              r_busy      <= 1'b1;
              r_rd_en     <= 1'b1;
              r_rd_addr   <= i_spcptr;
            end
          end
          S_READ: begin
            r_state <= S_WAIT;
          end
          S_WAIT: begin
            // RAM data arrives the cycle after the read strobe
            r_state      <= S_PRESENT;
            r_dout       <= bus.rd_data;
            r_dout_idx   <= r_idx;
            r_dout_valid <= 1'b1;
          end
          S_PRESENT: begin
            if (w_handshake) begin
              r_dout_valid <= 1'b0;
              if (r_remaining == (ADDR_WIDTH + 1)'(1)) begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end else begin
                r_state     <= S_READ;
                r_idx       <= w_idx_next;
                r_remaining <= r_remaining - (ADDR_WIDTH + 1)'(1);
                r_rd_en     <= 1'b1;
                r_rd_addr   <= w_addr_next;
              end
            end
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.rd_en      = r_rd_en;
  assign bus.rd_addr    = r_rd_addr;
  assign bus.dout       = r_dout;
  assign bus.dout_idx   = r_dout_idx;
  assign bus.dout_valid = r_dout_valid;
  assign o_busy         = r_busy;
  assign o_done         = r_done;
  assign o_aborted      = r_aborted;

endmodule

// File: tb/tb_spc_dump_reader.sv
// Bench for spc_dump_reader: models the stack RAM and checks each dump against the stack-walk rule.
// Latency: first entry expected 3 cycles after start, 3 cycles apart with ready high.
// Backpressure: dout_ready is driven low for stretches, randomly or deliberately.
module tb_spc_dump_reader;
  localparam int AW = 5;
  localparam int DW = 19;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          i_halted = 1'b0;
  logic          i_start = 1'b0;
  logic [AW-1:0] i_count = '0;
  logic [AW-1:0] i_spcptr = '0;
  logic          o_busy;
  logic          o_done;
  logic          o_aborted;

  logic [DW-1:0] ram [32];
  int checks = 0;
  int failures = 0;

  spc_dump_reader_if #(.AW(AW), .DW(DW)) bus ();

  spc_dump_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk      (clk),
    .reset    (reset),
    .i_halted (i_halted),
    .i_start  (i_start),
    .i_count  (i_count),
    .i_spcptr (i_spcptr),
    .bus      (bus),
    .o_busy   (o_busy),
    .o_done   (o_done),
    .o_aborted(o_aborted)
  );

  // Clock
  always #5 clk = ~clk;

  // Stack RAM aux port: data valid one cycle after the strobe
  always @(posedge clk) begin
    if (bus.rd_en) bus.rd_data <= ram[bus.rd_addr];
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Full dump with the expected stream derived from "entry k lives at (top - k) mod 32"
  task automatic run_dump(input logic [AW-1:0] ptr, input logic [AW-1:0] cnt,
                          input bit rand_ready, input bit poke);
    int n, got, rds, dones, cyc;
    logic [AW-1:0] ea;
    logic          hold;
    logic [DW-1:0] pd;
    logic [AW-1:0] pi;
    n = (cnt == 0) ? 32 : int'(cnt);
    got = 0; rds = 0; dones = 0; cyc = 0; hold = 1'b0; pd = '0; pi = '0;
    i_halted = 1'b1; i_spcptr = ptr; i_count = cnt; i_start = 1'b1;
    bus.dout_ready = 1'b1;
    tick;
    i_start = 1'b0; i_spcptr = AW'($urandom); i_count = AW'($urandom);
    while (dones == 0 && cyc < 800) begin
      if (bus.rd_en) begin
        ea = ptr - AW'(rds);
        checks++;
        if (bus.rd_addr !== ea) begin
          failures++; $display("FAIL rd_addr #%0d: got %0d want %0d", rds, bus.rd_addr, ea);
        end
        rds++;
      end
      if (hold) begin
        checks++;
        if (bus.dout !== pd || bus.dout_idx !== pi || bus.dout_valid !== 1'b1) begin
          failures++; $display("FAIL hold: got %h/%0d/%b want %h/%0d/1", bus.dout, bus.dout_idx, bus.dout_valid, pd, pi);
        end
      end
      if (o_done) dones++;
      if (dones == 0) begin
        bus.dout_ready = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
        if (poke) begin
          i_start = ($urandom_range(0, 3) == 0); i_spcptr = AW'($urandom); i_count = AW'($urandom);
        end
        hold = 1'b0;
        if (bus.dout_valid) begin
          if (bus.dout_ready) begin
            ea = ptr - AW'(got);
            checks++;
            if (bus.dout !== ram[ea] || bus.dout_idx !== AW'(got)) begin
              failures++; $display("FAIL entry #%0d: got %h/%0d want %h/%0d", got, bus.dout, bus.dout_idx, ram[ea], got);
            end
            got++;
          end else begin
            hold = 1'b1; pd = bus.dout; pi = bus.dout_idx;
          end
        end
        tick;
        cyc++;
      end
    end
    i_start = 1'b0;
    checks++;
    if (got !== n || rds !== n || dones !== 1) begin
      failures++; $display("FAIL dump_count: hs=%0d reads=%0d done=%0d want %0d/%0d/1", got, rds, dones, n, n);
    end
    checks++;
    if (o_aborted !== 1'b0 || o_busy !== 1'b0 || bus.dout_valid !== 1'b0) begin
      failures++; $display("FAIL dump_end: aborted=%b busy=%b valid=%b want 0/0/0", o_aborted, o_busy, bus.dout_valid);
    end
    tick;
    checks++;
    if (o_done !== 1'b0) begin
      failures++; $display("FAIL done_pulse: done=%b want 0", o_done);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; tick; tick;
    checks++;
    if ({bus.rd_en, bus.rd_addr, bus.dout, bus.dout_idx, bus.dout_valid, o_busy, o_done, o_aborted} !== '0) begin
      failures++; $display("FAIL reset: got rd_en=%b addr=%0d dout=%h idx=%0d valid=%b busy=%b done=%b ab=%b want all 0",
                           bus.rd_en, bus.rd_addr, bus.dout, bus.dout_idx, bus.dout_valid, o_busy, o_done, o_aborted);
    end
    reset = 1'b0; tick;
  endtask

  // Two-entry dump with exact cycle positions
  task automatic test_basic;
    logic [31:0] seen [8];
    ram[5] = 19'h1ABCD; ram[4] = 19'h00123;
    i_halted = 1'b1; i_spcptr = 5'd5; i_count = 5'd2; bus.dout_ready = 1'b1; i_start = 1'b1;
    for (int t = 1; t <= 7; t++) begin
      tick;
      i_start = 1'b0;
      seen[t] = {bus.rd_en, bus.rd_addr, bus.dout_valid, bus.dout_idx, o_done, o_aborted, 18'h0};
      if (t == 3 || t == 6) begin
        checks++;
        if (bus.dout_valid !== 1'b1 || bus.dout !== ((t == 3) ? 19'h1ABCD : 19'h00123) || bus.dout_idx !== ((t == 3) ? 5'd0 : 5'd1)) begin
          failures++; $display("FAIL basic_t%0d: got valid=%b dout=%h idx=%0d", t, bus.dout_valid, bus.dout, bus.dout_idx);
        end
      end
    end
    checks++;
    if (seen[1][31:26] !== {1'b1, 5'd5} || seen[4][31:26] !== {1'b1, 5'd4} || seen[2][31] !== 1'b0) begin
      failures++; $display("FAIL basic_reads: got t1=%h t2=%h t4=%h want rd 5 at t1, 4 at t4", seen[1][31:26], seen[2][31:26], seen[4][31:26]);
    end
    checks++;
    if (seen[7][19:18] !== 2'b10 || seen[6][19] !== 1'b0 || seen[7][25] !== 1'b0) begin
      failures++; $display("FAIL basic_done: got t6=%b t7 done/ab=%b want done only at t7", seen[6][19], seen[7][19:18]);
    end
    tick;
  endtask

  task automatic test_backpressure;
    logic [AW-1:0] ptr;
    logic [DW-1:0] d0;
    int cyc;
    ptr = AW'($urandom);
    i_halted = 1'b1; i_spcptr = ptr; i_count = 5'd2; bus.dout_ready = 1'b0; i_start = 1'b1;
    tick; i_start = 1'b0; tick; tick;
    d0 = bus.dout;
    checks++;
    if (bus.dout_valid !== 1'b1 || d0 !== ram[ptr]) begin
      failures++; $display("FAIL bp_first: got valid=%b dout=%h want 1/%h", bus.dout_valid, d0, ram[ptr]);
    end
    for (int i = 0; i < 10; i++) begin
      tick;
      checks++;
      if (bus.dout !== ram[ptr] || bus.dout_idx !== 5'd0 || bus.dout_valid !== 1'b1 || bus.rd_en !== 1'b0) begin
        failures++; $display("FAIL bp_stall%0d: got dout=%h idx=%0d valid=%b rd_en=%b", i, bus.dout, bus.dout_idx, bus.dout_valid, bus.rd_en);
      end
    end
    bus.dout_ready = 1'b1;
    tick;
    checks++;
    if (bus.rd_en !== 1'b1 || bus.rd_addr !== AW'(ptr - 5'd1) || bus.dout_valid !== 1'b0) begin
      failures++; $display("FAIL bp_resume: got rd_en=%b addr=%0d valid=%b want 1/%0d/0", bus.rd_en, bus.rd_addr, bus.dout_valid, AW'(ptr - 5'd1));
    end
    cyc = 0;
    while (!o_done && cyc < 20) begin tick; cyc++; end
    checks++;
    if (o_done !== 1'b1) begin
      failures++; $display("FAIL bp_timeout: done=%b want 1", o_done);
    end
    tick;
  endtask

  task automatic test_abort;
    int bad;
    i_halted = 1'b1; i_spcptr = AW'($urandom); i_count = 5'd4; bus.dout_ready = 1'b1; i_start = 1'b1;
    tick; i_start = 1'b0;
    for (int i = 0; i < 4; i++) tick;
    // Now in WAIT of the second entry
    i_halted = 1'b0;
    tick;
    checks++;
    if (bus.dout_valid !== 1'b0 || o_aborted !== 1'b1 || o_busy !== 1'b0 || o_done !== 1'b0) begin
      failures++; $display("FAIL abort: got valid=%b ab=%b busy=%b done=%b want 0/1/0/0", bus.dout_valid, o_aborted, o_busy, o_done);
    end
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      tick;
      if (o_done || bus.rd_en || bus.dout_valid || !o_aborted) bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++; $display("FAIL abort_quiet: got %0d bad cycles want 0", bad);
    end
    // Start while not halted is ignored
    i_start = 1'b1; tick; i_start = 1'b0; tick;
    checks++;
    if (bus.rd_en !== 1'b0 || o_busy !== 1'b0 || o_aborted !== 1'b1) begin
      failures++; $display("FAIL start_nohalt: got rd_en=%b busy=%b ab=%b want 0/0/1", bus.rd_en, o_busy, o_aborted);
    end
    // Abort beats a handshake in PRESENT
    i_halted = 1'b1; i_count = 5'd3; bus.dout_ready = 1'b0; i_start = 1'b1;
    tick; i_start = 1'b0;
    checks++;
    if (o_aborted !== 1'b0 || o_busy !== 1'b1) begin
      failures++; $display("FAIL abort_clear: got ab=%b busy=%b want 0/1", o_aborted, o_busy);
    end
    tick; tick;
    bus.dout_ready = 1'b1; i_halted = 1'b0;
    tick;
    checks++;
    if (o_done !== 1'b0 || o_aborted !== 1'b1 || bus.dout_valid !== 1'b0 || o_busy !== 1'b0) begin
      failures++; $display("FAIL abort_prio: got done=%b ab=%b valid=%b busy=%b want 0/1/0/0", o_done, o_aborted, bus.dout_valid, o_busy);
    end
    tick;
    checks++;
    if (bus.rd_en !== 1'b0) begin
      failures++; $display("FAIL abort_noread: rd_en=%b want 0", bus.rd_en);
    end
  endtask

  task automatic test_reset_mid;
    i_halted = 1'b1; i_spcptr = AW'($urandom); i_count = 5'd5; bus.dout_ready = 1'b0; i_start = 1'b1;
    tick; i_start = 1'b0; tick; tick;
    reset = 1'b1;
    tick;
    checks++;
    if ({bus.rd_en, bus.rd_addr, bus.dout, bus.dout_idx, bus.dout_valid, o_busy, o_done, o_aborted} !== '0) begin
      failures++; $display("FAIL reset_mid: got valid=%b dout=%h busy=%b want all 0", bus.dout_valid, bus.dout, o_busy);
    end
    reset = 1'b0;
    tick;
    checks++;
    if (o_done !== 1'b0 || o_busy !== 1'b0) begin
      failures++; $display("FAIL reset_mid_after: done=%b busy=%b want 0/0", o_done, o_busy);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) ram[i] = DW'($urandom);
    bus.dout_ready = 1'b0;
    test_reset;
    test_basic;
    run_dump(5'd1, 5'd3, 1'b0, 1'b0);
    run_dump(AW'($urandom), 5'd0, 1'b0, 1'b0);
    run_dump(AW'($urandom), 5'd0, 1'b1, 1'b1);
    test_backpressure;
    test_abort;
    run_dump(5'd2, 5'd4, 1'b1, 1'b0);
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 32; i++) ram[i] = DW'($urandom);
      run_dump(AW'($urandom), AW'($urandom), 1'b1, 1'b1);
    end
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/spc_dump_reader.md
Name:
spc_dump_reader

Overview:
- Debug-side reader for the SPC micro-PC return stack. While the processor is halted, it walks the stack from the current top of stack downward.
- Each entry is read through an auxiliary read port on the stack RAM. Entries are streamed to the spy/debug interface with a valid/ready handshake.
- The block sits between the SPC stack RAM and the debug bus. It is the consumer of the stack contents that the microsequencer writes.

Parameters:
ADDR_WIDTH, 5, stack address and pointer width (depth = 2**ADDR_WIDTH).
DATA_WIDTH, 19, stack entry width.

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
halted  in  1  processor halted; dump permitted only while high
start  in  1  single-cycle dump request
count  in  ADDR_WIDTH  number of entries to read; 0 means full depth (32)
spcptr  in  ADDR_WIDTH  current SPC stack pointer (top of stack)
rd_en  out  1  read strobe to stack RAM aux port
rd_addr  out  ADDR_WIDTH  read address to stack RAM aux port
rd_data  in  DATA_WIDTH  stack RAM read data, valid exactly 1 cycle after rd_en
dout  out  DATA_WIDTH  entry presented to debug bus
dout_idx  out  ADDR_WIDTH  depth offset of dout (0 = top of stack)
dout_valid  out  1  dout/dout_idx valid
dout_ready  in  1  debug bus accepts entry
busy  out  1  dump in progress (state != IDLE)
done  out  1  one-cycle pulse, dump completed normally
aborted  out  1  sticky flag, dump terminated by halted falling; cleared by next accepted start

Behaviour:
- Reset: state IDLE. All outputs 0: rd_en, rd_addr, dout, dout_idx, dout_valid, busy, done, aborted. Reset mid-dump abandons it with no done pulse.
- Internal state: base (ADDR_WIDTH), idx (ADDR_WIDTH), remaining (ADDR_WIDTH+1 bits, range 1..32).
- IDLE:
  - start && halted: latch base=spcptr, idx=0, remaining=(count==0 ? 32 : count), clear aborted, go to READ.
  - start && !halted: ignored; aborted unchanged.
  - start while busy: ignored.
- READ (1 cycle): rd_en=1, rd_addr=(base - idx) mod 2**ADDR_WIDTH; go to WAIT. rd_en is high only in READ.
- WAIT (1 cycle): register rd_data into dout and idx into dout_idx; go to PRESENT.
- PRESENT:
  - dout_valid=1; dout and dout_idx held stable until the handshake.
  - Handshake = dout_valid && dout_ready.
  - Handshake with remaining==1: dout_valid drops next cycle, done pulses for 1 cycle, go to IDLE.
  - Handshake otherwise: idx++, remaining--, go to READ.
- Timing:
  - Latency from start to first dout_valid: 3 cycles (start at t; READ t+1; WAIT t+2; dout_valid at t+3).
  - Minimum spacing between entries with ready held high: 3 cycles.
- Wrap-around: address arithmetic is modulo depth. base=2, count=4 reads addresses 2,1,0,31.
- Full dump (count=0) reads all 32 entries. idx covers 0..31; remaining needs the extra bit.
- Abort: halted low in any non-IDLE state →
  - next cycle IDLE, dout_valid=0, aborted=1, no done;
  - any in-flight read data is discarded.
  - Abort takes priority over a handshake in the same cycle; that entry counts as not delivered.
- spcptr changes after start are ignored; base is latched.
- dout retains its last value after completion. Only dout_valid qualifies it.

Test Plan:
- RAM[5]=0x1ABCD, RAM[4]=0x00123, spcptr=5, count=2, dout_ready=1 → rd_addr 5 then 4; dout=0x1ABCD idx0 at t+3, 0x00123 idx1 at t+6; done pulse at t+7; aborted=0.
- spcptr=1, count=3 → rd_addr sequence 1,0,31; dout_idx 0,1,2.
- count=0 → exactly 32 handshakes; last rd_addr=(spcptr+1) mod 32; single done pulse.
- dout_ready low 10 cycles in PRESENT → dout/dout_idx stable, no further rd_en; resumes on ready.
- halted deasserted during WAIT of entry 2 of 4 → dout_valid=0 next cycle, aborted=1, no done. Next start with halted=1 clears aborted.
- start with halted=0, and start while busy → no rd_en, busy unchanged. Reset asserted during PRESENT → all outputs 0 next cycle.
